// File: rtl/emmc_req_arbiter.sv
// rtl/emmc_req_arbiter.sv - round-robin arbiter sharing the emmc_sm user interface among clients
`timescale 1ns/1ps
module emmc_req_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int BLK_CNT_WIDTH = 16,
    parameter int ACK_TIMEOUT   = 1024
) (
    input  logic                             clk_i,
    input  logic                             arst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               req_we_i,
    input  logic [NUM_REQ*BLK_CNT_WIDTH-1:0] req_blk_cnt_i,
    input  logic [NUM_REQ*8-1:0]             req_dat_i,
    output logic [NUM_REQ-1:0]               grant_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic [NUM_REQ-1:0]               err_o,
    output logic [NUM_REQ-1:0]               dvalid_o,
    output logic [7:0]                       rd_dat_o,
    output logic                             emmc_we_o,
    output logic                             emmc_start_o,
    output logic [BLK_CNT_WIDTH-1:0]         emmc_blk_cnt_o,
    output logic [7:0]                       emmc_dat_o,
    input  logic [7:0]                       emmc_dat_i,
    input  logic                             emmc_dvalid_i,
    input  logic                             emmc_ready_i
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] sel;
    logic [TMR_W-1:0] timer;
    logic [IDX_W-1:0] pick;
    logic             pick_valid;

    // Scan clients above last first, then wrap around to those at or below it.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && req_i[i] && (IDX_W'(i) > last)) begin
                pick_valid = 1'b1;
                pick       = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && req_i[i] && (IDX_W'(i) <= last)) begin
                pick_valid = 1'b1;
                pick       = IDX_W'(i);
            end
        end
    end

    always_comb begin
        emmc_dat_o = '0;
        if (|grant_o) begin
            emmc_dat_o = req_dat_i[int'(sel)*8 +: 8];
        end
    end

    assign dvalid_o = {NUM_REQ{emmc_dvalid_i}} & grant_o;
    assign rd_dat_o = emmc_dat_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state          <= S_IDLE;
            last           <= IDX_W'(NUM_REQ - 1);
            sel            <= '0;
            timer          <= '0;
            grant_o        <= '0;
            done_o         <= '0;
            err_o          <= '0;
            emmc_we_o      <= 1'b0;
            emmc_start_o   <= 1'b0;
            emmc_blk_cnt_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (emmc_ready_i && pick_valid) begin
                        sel            <= pick;
                        grant_o        <= NUM_REQ'(1) << pick;
                        emmc_we_o      <= req_we_i[pick];
                        emmc_blk_cnt_o <= req_blk_cnt_i[int'(pick)*BLK_CNT_WIDTH +: BLK_CNT_WIDTH];
                        state          <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    // emmc_sm would silently ignore a zero-block start, so fail it here.
                    if (emmc_blk_cnt_o == '0) begin
                        done_o <= grant_o;
                        err_o  <= grant_o;
                        state  <= S_DONE;
                    end else begin
                        emmc_start_o <= 1'b1;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    emmc_start_o <= 1'b0;
                    // The start cycle itself counts toward the acknowledge window.
                    timer        <= TMR_W'(1);
                    state        <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!emmc_ready_i) begin
                        state <= S_WAIT_DONE;
                    end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        done_o <= grant_o;
                        err_o  <= grant_o;
                        state  <= S_DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (emmc_ready_i) begin
                        done_o <= grant_o;
                        err_o  <= '0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_o         <= '0;
                    err_o          <= '0;
                    grant_o        <= '0;
                    emmc_we_o      <= 1'b0;
                    emmc_blk_cnt_o <= '0;
                    last           <= sel;
                    state          <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_emmc_req_arbiter.sv
// tb/tb_emmc_req_arbiter.sv - self-checking bench for emmc_req_arbiter with a round-robin reference model
`timescale 1ns/1ps
module tb_emmc_req_arbiter;
    localparam int N  = 2;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   req_we;
    logic [N*W-1:0] req_blk;
    logic [N*8-1:0] req_dat;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic [N-1:0]   dvalid_o;
    logic [7:0]     rd_dat;
    logic           e_we;
    logic           e_start;
    logic [W-1:0]   e_blk;
    logic [7:0]     e_dat_o;
    logic [7:0]     e_dat_i;
    logic           e_dvalid;
    logic           e_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int last_m;

    always #5 clk = ~clk;

    emmc_req_arbiter #(
        .NUM_REQ      (N),
        .BLK_CNT_WIDTH(W),
        .ACK_TIMEOUT  (TO)
    ) dut (
        .clk_i         (clk),
        .arst_i        (rst),
        .req_i         (req),
        .req_we_i      (req_we),
        .req_blk_cnt_i (req_blk),
        .req_dat_i     (req_dat),
        .grant_o       (grant),
        .done_o        (done),
        .err_o         (err),
        .dvalid_o      (dvalid_o),
        .rd_dat_o      (rd_dat),
        .emmc_we_o     (e_we),
        .emmc_start_o  (e_start),
        .emmc_blk_cnt_o(e_blk),
        .emmc_dat_o    (e_dat_o),
        .emmc_dat_i    (e_dat_i),
        .emmc_dvalid_i (e_dvalid),
        .emmc_ready_i  (e_ready)
    );

    // Reference arbitration: first requesting client after the last winner, cyclically.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (last + i) % N;
            if (((r >> j) & 2'b01) != 2'b00) return j;
        end
        return 0;
    endfunction

    // One transaction. The card model drops ready a cycles after start and raises it
    // b cycles later; a == 0 means ready never drops, so the acknowledge timeout fires.
    task automatic run_txn(input int a, input int b, input bit drop_req, input bit jitter,
                           input bit reset_mid);
        int         k, t_done, g;
        bit         seen, timeout;
        logic [N-1:0] mask;
        logic [W-1:0] blk;
        logic         we;
        k       = rr_pick(req, last_m);
        mask    = 2'(1 << k);
        blk     = req_blk[k*W +: W];
        we      = req_we[k];
        timeout = (a == 0);
        t_done  = timeout ? TO : a + b + 1;
        seen    = 0;
        g       = 0;
        while (!seen && g < 20) begin
            @(negedge clk); #1;
            g++;
            if (grant !== 2'b00) seen = 1;
        end
        n_cmp++;
        if (grant !== mask || g != 1) begin
            n_bad++;
            $display("FAIL grant: got %b after %0d cycles, required %b after 1", grant, g, mask);
        end
        n_cmp++;
        if (e_we !== we || e_blk !== blk || e_start !== 1'b0) begin
            n_bad++;
            $display("FAIL latch: we=%b blk=%0d start=%b, required we=%b blk=%0d start=0",
                     e_we, e_blk, e_start, we, blk);
        end
        @(negedge clk); #1;
        if (blk == 0) begin
            n_cmp++;
            if (done !== mask || err !== mask || e_start !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_blk: done=%b err=%b start=%b, required done=%b err=%b start=0",
                         done, err, e_start, mask, mask);
            end
            @(negedge clk); #1;
            n_cmp++;
            if (done !== 2'b00 || grant !== 2'b00 || e_start !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_release: done=%b grant=%b start=%b, required 00 00 0",
                         done, grant, e_start);
            end
            last_m = k;
            return;
        end
        n_cmp++;
        if (e_start !== 1'b1 || done !== 2'b00) begin
            n_bad++;
            $display("FAIL start: start=%b done=%b, required start=1 done=00", e_start, done);
        end
        for (int t = 1; t <= t_done + 1; t++) begin
            @(negedge clk);
            if (jitter) req_dat = 16'($urandom);
            e_dat_i = 8'($urandom);
            if (drop_req && t == 1) req = req & ~mask;
            if (!timeout && t == a) e_ready = 1'b0;
            if (!timeout && t == a + b) e_ready = 1'b1;
            e_dvalid = (!timeout && b >= 2 && t == a + 1);
            #1;
            n_cmp++;
            if (done !== ((t == t_done) ? mask : 2'b00) ||
                err !== ((t == t_done && timeout) ? mask : 2'b00)) begin
                n_bad++;
                $display("FAIL done t=%0d: done=%b err=%b, required done=%b err=%b", t, done, err,
                         (t == t_done) ? mask : 2'b00, (t == t_done && timeout) ? mask : 2'b00);
            end
            if (t <= t_done) begin
                n_cmp++;
                if (grant !== mask || e_start !== 1'b0 || e_we !== we || e_blk !== blk ||
                    e_dat_o !== req_dat[k*8 +: 8]) begin
                    n_bad++;
                    $display("FAIL hold t=%0d: grant=%b start=%b we=%b blk=%0d dat=%h, required %b 0 %b %0d %h",
                             t, grant, e_start, e_we, e_blk, e_dat_o, mask, we, blk, req_dat[k*8 +: 8]);
                end
                n_cmp++;
                if (dvalid_o !== (e_dvalid ? mask : 2'b00) || rd_dat !== e_dat_i) begin
                    n_bad++;
                    $display("FAIL route t=%0d: dvalid=%b rd_dat=%h, required %b %h", t, dvalid_o,
                             rd_dat, e_dvalid ? mask : 2'b00, e_dat_i);
                end
            end else begin
                n_cmp++;
                if (grant !== 2'b00 || e_we !== 1'b0 || e_blk !== '0 || e_dat_o !== 8'h00) begin
                    n_bad++;
                    $display("FAIL release: grant=%b we=%b blk=%0d dat=%h, required all zero",
                             grant, e_we, e_blk, e_dat_o);
                end
            end
            if (reset_mid && t == a + 1) begin
                rst = 1'b1;
                #1;
                n_cmp++;
                if (grant !== 2'b00 || done !== 2'b00 || err !== 2'b00 || dvalid_o !== 2'b00 ||
                    e_start !== 1'b0 || e_we !== 1'b0 || e_blk !== '0 || e_dat_o !== 8'h00) begin
                    n_bad++;
                    $display("FAIL async_reset: grant=%b done=%b err=%b dvalid=%b start=%b we=%b blk=%0d dat=%h, required all zero",
                             grant, done, err, dvalid_o, e_start, e_we, e_blk, e_dat_o);
                end
                @(negedge clk); #1;
                n_cmp++;
                if (done !== 2'b00 || grant !== 2'b00) begin
                    n_bad++;
                    $display("FAIL reset_hold: done=%b grant=%b, required 00 00", done, grant);
                end
                rst      = 1'b0;
                e_ready  = 1'b1;
                e_dvalid = 1'b0;
                req      = '0;
                last_m   = N - 1;
                return;
            end
        end
        e_dvalid = 1'b0;
        last_m   = k;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req      = 2'b11;
        req_we   = 2'b10;
        req_blk  = {8'd3, 8'd2};
        req_dat  = {8'h5A, 8'h3C};
        e_dat_i  = 8'h77;
        e_dvalid = 1'b1;
        e_ready  = 1'b1;
        last_m   = N - 1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (grant !== 2'b00 || done !== 2'b00 || err !== 2'b00 || dvalid_o !== 2'b00 ||
            e_start !== 1'b0 || e_we !== 1'b0 || e_blk !== '0 || e_dat_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset: grant=%b done=%b err=%b dvalid=%b start=%b we=%b blk=%0d dat=%h, required all zero",
                     grant, done, err, dvalid_o, e_start, e_we, e_blk, e_dat_o);
        end
        n_cmp++;
        if (rd_dat !== 8'h77) begin
            n_bad++;
            $display("FAIL reset_rd_dat: got %h, required 77", rd_dat);
        end
        e_dvalid = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            run_txn(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (last_m != (i % 2)) begin
                n_bad++;
                $display("FAIL alternate %0d: winner %0d, required %0d", i, last_m, i % 2);
            end
        end
        req = '0;
    endtask

    task automatic test_single_read();
        req_we       = 2'b00;
        req_blk[7:0] = 8'd1;
        req          = 2'b01;
        run_txn(3, 20, 1'b0, 1'b0, 1'b0);
        req = '0;
    endtask

    task automatic test_zero_blk();
        req_blk[15:8] = 8'd0;
        req           = 2'b10;
        run_txn(1, 1, 1'b0, 1'b0, 1'b0);
        req = '0;
    endtask

    task automatic test_timeout();
        req_blk = {8'd4, 8'd5};
        req     = 2'b01;
        run_txn(0, 1, 1'b0, 1'b0, 1'b0);
        req = 2'b10;
        run_txn(2, 3, 1'b0, 1'b0, 1'b0);
        req = '0;
    endtask

    task automatic test_write_route();
        req_we        = 2'b10;
        req_blk[15:8] = 8'd2;
        req_dat       = {8'hA5, 8'h11};
        req           = 2'b10;
        run_txn(2, 5, 1'b0, 1'b0, 1'b0);
        req = '0;
    endtask

    task automatic test_reset_mid();
        req_blk = {8'd4, 8'd6};
        req     = 2'b10;
        run_txn(2, 8, 1'b0, 1'b0, 1'b1);
        req = 2'b11;
        run_txn(2, 2, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (last_m != 0) begin
            n_bad++;
            $display("FAIL after_reset: winner %0d, required 0", last_m);
        end
        req = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int a;
            req_we = 2'($urandom);
            for (int c = 0; c < N; c++) begin
                req_blk[c*W +: W] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            req_dat = 16'($urandom);
            a       = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            req     = 2'($urandom_range(1, 3));
            run_txn(a, int'($urandom_range(1, 8)), 1'($urandom), 1'b1, 1'b0);
            req = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alternate();
        test_single_read();
        test_zero_blk();
        test_timeout();
        test_write_route();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
